div_unsigned_radix2_seq: RTL
============================

# div_unsigned_radix2_seq

Iterative unsigned radix-2 restoring divider that implements the `divider` side of `unsigned_division_interface`. It accepts a single-cycle `start` pulse with operands and returns quotient and remainder with a single-cycle `done` pulse. It has fast paths for a zero divisor and for dividend < divisor. The div unit instantiates it as its arithmetic core; the div unit is the requester.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.

- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle request pulse. Operands are sampled in the same cycle.
- `dividend`  in  DATA_WIDTH: numerator, valid with `start`.
- `divisor`  in  DATA_WIDTH: denominator, valid with `start`.
- `quotient`  out  DATA_WIDTH: result quotient, valid in the `done` cycle.
- `remainder`  out  DATA_WIDTH: result remainder, valid in the `done` cycle.
- `done`  out  1: single-cycle completion pulse.
- `divisor_is_zero`  out  1: set when the completed operation had divisor == 0; valid in the `done` cycle.

## Operation
- States: IDLE and RUN. A DONE state is not needed; `done` is a registered flag.
- Counter width: $clog2(DATA_WIDTH+1).
- IDLE + `start` (operands sampled at end of cycle 0):
  - divisor == 0: go to IDLE. Result: `done`=1, `quotient`=all-ones, `remainder`=dividend, `divisor_is_zero`=1. These are RISC-V DIVU/REMU semantics.
  - Else dividend < divisor: go to IDLE. Result: `done`=1, `quotient`=0, `remainder`=dividend, `divisor_is_zero`=0.
  - Else: load the working registers (quotient shift reg = dividend, partial remainder = 0, divisor latched), set counter = DATA_WIDTH, go to RUN.
- RUN, each cycle:
  - t = {partial_rem[DATA_WIDTH-2:0], q[DATA_WIDTH-1]}, computed DATA_WIDTH+1 bits wide with a leading 0.
  - diff = t − divisor, computed DATA_WIDTH+1 bits wide.
  - If diff is non-negative (MSB 0): partial_rem = diff[DATA_WIDTH-1:0] and shift a 1 into q. Otherwise partial_rem = t and shift a 0 into q.
  - Decrement the counter. On the iteration where the counter reaches 0, register `done`=1 and go to IDLE.
- `quotient` and `remainder` are driven directly from the working registers.
  - During RUN their values are unspecified. The bench checks them only when `done`=1.
  - After `done` they hold until the next accepted `start`.
- `start` in RUN: abort the current operation and restart with the new operands, following the IDLE rules. The aborted operation never produces `done`. The requester uses this on pipeline flush.
- `start` in the same cycle that `done` is high: accepted normally, because the state is already IDLE.
- `rst` at any time: state returns to IDLE. All outputs and the counter go to 0. Any in-flight operation is discarded with no `done`.

## Timing
- Reset values: `done`=0, `quotient`=0, `remainder`=0, `divisor_is_zero`=0, state IDLE, counter 0.
- Cycle numbering: `start` is high in cycle 0.
- Fast paths: `done` is high in cycle 1.
- Normal path: iterations occur at the ends of cycles 1..DATA_WIDTH, and `done` is high in cycle DATA_WIDTH+1 (33 for the default).
- A restart in cycle k produces `done` in cycle k+1 (fast path) or k+DATA_WIDTH+1 (normal path).
- `done` is high for exactly one cycle per completed operation.
- `divisor_is_zero` is cleared on every accepted `start` that has a nonzero divisor.
- Throughput: one operation per DATA_WIDTH+1 cycles, achieved with back-to-back `start` issued in each `done` cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Single module with no sub-module.
- The state enum is a local typedef inside the module. Nothing is added to `taiga_types`, because DATA_WIDTH is set per instance.
- Port list matches the `divider` modport exactly, so the top-level div unit connects it through the interface without renaming.

## Test plan
All scenarios use DATA_WIDTH=32.
- 100 / 7 → in cycle 33: `quotient`=14, `remainder`=2, `divisor_is_zero`=0. `done` is low in cycles 1–32 and 34.
- 0x12345678 / 0 → in cycle 1: `done`=1, `quotient`=0xFFFFFFFF, `remainder`=0x12345678, `divisor_is_zero`=1.
- 5 / 9 → in cycle 1: `quotient`=0, `remainder`=5. Also 0xFFFFFFFF / 0xFFFFFFFF → cycle 33: `quotient`=1, `remainder`=0. 0xFFFFFFFF / 1 → cycle 33: `quotient`=0xFFFFFFFF, `remainder`=0.
- Start 1000 / 3 at cycle 0, then restart with 50 / 5 at cycle 10 → exactly one `done`, in cycle 43, with `quotient`=10, `remainder`=0.
- Start 1000 / 3, assert `rst` in cycle 15 → `done` never asserts and all outputs read 0. A subsequent 9 / 2 → `quotient`=4, `remainder`=1 after 33 cycles.
- Back-to-back: 100 / 7, then 77 / 10 started in the `done` cycle (33) → second `done` in cycle 66 with `quotient`=7, `remainder`=7.
- Random soak: 10k operations with random operands, random restarts, and random `rst`. A scoreboard checks the RISC-V DIVU/REMU model and the exactly-one-`done` rule.

Source files
------------

// File: rtl/div_unsigned_radix2_seq_pkg.sv
// Shared constants for the radix-2 restoring divider.
package div_unsigned_radix2_seq_pkg;

    localparam int DIV_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/div_unsigned_radix2_seq.sv
// Iterative unsigned radix-2 restoring divider.
// Handles zero-divisor and dividend < divisor in a single cycle.
module div_unsigned_radix2_seq
    import div_unsigned_radix2_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  done,
    output logic                  divisor_is_zero
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_div;
    logic                  r_done;
    logic                  r_dz;

    logic [DATA_WIDTH:0]   w_t;
    logic [DATA_WIDTH:0]   w_diff;

    // Partial remainder stays below 2^(iteration) so its MSB is never lost here.
    assign w_t    = {1'b0, r_rem[DATA_WIDTH-2:0], r_q[DATA_WIDTH-1]};
    assign w_diff = w_t - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                if (divisor == '0) begin
                    r_q     <= '1;
                    r_rem   <= dividend;
                    r_dz    <= 1'b1;
                    r_done  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end else if (dividend < divisor) begin
                    r_q     <= '0;
                    r_rem   <= dividend;
                    r_dz    <= 1'b0;
                    r_done  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end else begin
                    r_q     <= dividend;
                    r_rem   <= '0;
                    r_div   <= divisor;
                    r_dz    <= 1'b0;
                    r_cnt   <= CW'(DATA_WIDTH);
                    r_state <= RUN;
                end
            end else if (r_state == RUN) begin
                r_q   <= {r_q[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
                r_rem <= w_diff[DATA_WIDTH] ? w_t[DATA_WIDTH-1:0]
                                            : w_diff[DATA_WIDTH-1:0];
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
            end
        end
    end

    assign quotient        = r_q;
    assign remainder       = r_rem;
    assign done            = r_done;
    assign divisor_is_zero = r_dz;

endmodule
